// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if: EX resolve inputs, redirect/flush outputs and branch-buffer update port
interface branch_resolve_ctrl_if #(
    parameter int PC_W  = 5,
    parameter int CNT_W = 8
);
    logic             EX_valid;
    logic             EX_brn;
    logic             EX_stall;
    logic [PC_W-1:0]  EX_pc;
    logic             EX_pred_taken;
    logic [PC_W-1:0]  EX_pred_target;
    logic             EX_true_taken;
    logic [PC_W-1:0]  EX_alu_out;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_F;
    logic             flush_D;
    logic             stall_req;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [PC_W-1:0]  upd_target;
    logic             upd_taken;
    logic             upd_ready;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;
    modport master (
        output EX_valid, EX_brn, EX_stall, EX_pc, EX_pred_taken, EX_pred_target,
               EX_true_taken, EX_alu_out, upd_ready,
        input  redirect_valid, redirect_pc, flush_F, flush_D, stall_req, upd_valid,
               upd_pc, upd_target, upd_taken, branch_cnt, mispredict_cnt
    );
    modport slave (
        input  EX_valid, EX_brn, EX_stall, EX_pc, EX_pred_taken, EX_pred_target,
               EX_true_taken, EX_alu_out, upd_ready,
        output redirect_valid, redirect_pc, flush_F, flush_D, stall_req, upd_valid,
               upd_pc, upd_target, upd_taken, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves EX branches, drives redirect/flush, queues updates toward the branch buffer
module branch_resolve_ctrl #(
    parameter int PC_W      = 5,
    parameter int UPD_DEPTH = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 8
) (
    input logic clk,
    input logic rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYC + 1);
    localparam int ENT_W = 2 * PC_W + 1;
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t           state, state_n;
    logic [FC_W-1:0]  fcnt, fcnt_n;
    logic [ENT_W-1:0] mem [UPD_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             flushing, empty, full, pop, full_block, cand, accept, mispredict, fire;
    logic [PC_W-1:0]  correct_pc;
    assign flushing   = state == FLUSH;
    assign empty      = count == '0;
    assign full       = count == (PTR_W + 1)'(UPD_DEPTH);
    assign pop        = !empty && bus.upd_ready;
    assign full_block = full && !pop;
    assign cand       = bus.EX_valid && bus.EX_brn && !flushing;
    assign accept     = cand && !bus.EX_stall && !full_block;
    assign mispredict = (bus.EX_pred_taken != bus.EX_true_taken) ||
                        (bus.EX_true_taken && bus.EX_pred_target != bus.EX_alu_out);
    assign fire       = accept && mispredict;
    assign correct_pc = bus.EX_true_taken ? bus.EX_alu_out : bus.EX_pc + PC_W'(1);
    assign wr_ptr     = rd_ptr + count[PTR_W-1:0];
    assign bus.stall_req      = cand && full_block;
    assign bus.redirect_valid = fire;
    assign bus.redirect_pc    = fire ? correct_pc : '0;
    assign bus.flush_F        = fire || flushing;
    assign bus.flush_D        = fire || flushing;
    assign bus.upd_valid      = !empty;
    assign {bus.upd_pc, bus.upd_target, bus.upd_taken} = empty ? '0 : mem[rd_ptr];
    // Flush window: cycle 0 is combinational, the FSM covers the remaining FLUSH_CYC-1 cycles
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        if (state == IDLE) begin
            if (fire && FLUSH_CYC > 1) begin
                state_n = FLUSH;
                fcnt_n  = FC_W'(FLUSH_CYC - 1);
            end
        end else begin
            fcnt_n  = fcnt - FC_W'(1);
            state_n = (fcnt == FC_W'(1)) ? IDLE : FLUSH;
        end
    end
    // FSM state and flush down-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end
    // Update FIFO payload storage; validity lives in count so no reset needed
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {bus.EX_pc, bus.EX_alu_out, bus.EX_true_taken};
    end
    // Update FIFO read pointer and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W + 1)'(accept) - (PTR_W + 1)'(pop);
        end
    end
    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.branch_cnt     <= '0;
            bus.mispredict_cnt <= '0;
        end else begin
            if (accept && bus.branch_cnt != '1) bus.branch_cnt <= bus.branch_cnt + CNT_W'(1);
            if (fire && bus.mispredict_cnt != '1) bus.mispredict_cnt <= bus.mispredict_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Resolves branches in EX against the prediction carried down from IF. On a misprediction it issues the PC redirect and the IF/ID flush window. It also queues every resolved branch into a small FIFO that drains, one entry per handshake, into the branch target buffer's update port. It sits between the EX stage, the IF PC mux, the pipeline flush/stall logic and the branch buffer write side.

Parameters:
PC_W, 5, PC width (word-addressed; sequential PC = pc+1 mod 2^PC_W)
UPD_DEPTH, 4, update FIFO depth (power of two, >=2)
FLUSH_CYC, 2, total cycles flush_F/flush_D stay asserted per mispredict (>=1)
CNT_W, 8, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
EX_valid  in  1  EX holds a real (non-bubble) instruction
EX_brn  in  1  EX instruction is a conditional branch
EX_stall  in  1  EX is held by some other source this cycle
EX_pc  in  PC_W  PC of EX instruction
EX_pred_taken  in  1  prediction made at fetch
EX_pred_target  in  PC_W  predicted next PC made at fetch
EX_true_taken  in  1  resolved direction
EX_alu_out  in  PC_W  resolved taken target
redirect_valid  out  1  load redirect_pc into the PC this edge
redirect_pc  out  PC_W  corrected next PC
flush_F  out  1  squash IF instruction
flush_D  out  1  squash ID instruction
stall_req  out  1  hold EX (update FIFO cannot accept)
upd_valid  out  1  FIFO head valid toward branch buffer
upd_pc  out  PC_W  head entry PC
upd_target  out  PC_W  head entry resolved target
upd_taken  out  1  head entry resolved direction
upd_ready  in  1  branch buffer accepts head this edge
branch_cnt  out  CNT_W  resolved branches, saturating
mispredict_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; counters 0. Reset wins over every other event, including mid-flush and a full FIFO.
- FSM: IDLE, FLUSH. The flush down-counter is loaded with FLUSH_CYC-1.
- flushing = (state==FLUSH).
- pop = upd_valid & upd_ready.
- full_block = full & !pop.
- cand = EX_valid & EX_brn & !flushing.
- accept = cand & !EX_stall & !full_block.
- stall_req = cand & full_block. It is combinational and does not depend on EX_stall. The pipeline ORs it into its own EX hold.
- mispredict = (EX_pred_taken != EX_true_taken) | (EX_true_taken & EX_pred_target != EX_alu_out).
- correct_pc = EX_true_taken ? EX_alu_out : EX_pc+1, with wrap modulo 2^PC_W (e.g. 31+1 = 0).
- Redirect is combinational in the resolving cycle: redirect_valid = accept & mispredict, and redirect_pc = correct_pc. redirect_pc = 0 whenever redirect_valid = 0.
- Flush, cycle 0: flush_F = flush_D = accept & mispredict.
- Flush, following cycles: if FLUSH_CYC > 1, FSM goes IDLE->FLUSH at that edge. In FLUSH, flush_F = flush_D = 1. The counter decrements each cycle, and FSM returns to IDLE after the cycle it reads 1. Total flush assertion is exactly FLUSH_CYC cycles.
- In FLUSH, EX branches are wrong-path: no accept, no enqueue, no count, no stall_req.
- If FLUSH_CYC = 1, FSM never leaves IDLE.
- FIFO: circular, with ptr and count registers. Push = accept, entry {EX_pc, EX_alu_out, EX_true_taken}. Every resolved branch is pushed, correct or not. Head is driven combinationally on upd_*, and upd_valid = !empty.
- Simultaneous push and pop is allowed when full or empty. On empty, the pushed entry appears on upd_* in the following cycle; there is no bypass.
- Counters, updated at the edge: branch_cnt++ on accept; mispredict_cnt++ on accept & mispredict. Both saturate at 2^CNT_W-1.
- EX_stall held: no redirect and no push. The same branch is accepted once, in its first unstalled cycle.

Test Plan:
1. Correct not-taken: EX_pc=4, pred_taken=0, true_taken=0 -> redirect_valid=0, flush_F=0; upd_valid=1 next cycle with {4, alu_out, 0}; branch_cnt=1, mispredict_cnt=0.
2. Direction mispredict: EX_pc=7, pred_taken=0, true_taken=1, alu_out=20 -> same cycle redirect_valid=1, redirect_pc=20; flush_F/flush_D high 2 cycles. A branch presented in EX during cycle 2 is ignored (branch_cnt unchanged). mispredict_cnt=1.
3. Target mismatch plus wrap: first, pred_taken=1, true_taken=1, pred_target=9, alu_out=12 -> redirect_pc=12. Then EX_pc=31, pred_taken=1, true_taken=0 -> redirect_pc=0.
4. Backpressure: upd_ready=0, push 4 branches (FIFO full). A 5th branch -> stall_req=1, no redirect, counters frozen. Raise upd_ready -> same cycle accept with push+pop; head order preserved 1,2,3,4,5.
5. EX_stall held 3 cycles on a mispredicting branch -> exactly one redirect pulse, one push, branch_cnt+1.
6. Reset mid-flush with 2 entries queued -> next cycle all outputs 0, upd_valid=0, counters 0, FSM IDLE. Separately, force 300 accepts with CNT_W=8 -> branch_cnt saturates at 255.
